// File: rtl/hansen_soc_mem_io.sv
// rtl/hansen_soc_mem_io.sv - unified RAM + MMIO page (LED, buffered 8N1 UART TX, status) for hansen_core
// Optional feature macro: HANSEN_MMIO_TIMER_EN (free-running cycle counter readable at IO 0xC)
module hansen_soc_mem_io #(
  parameter int MEM_WORDS = 512,
  parameter     INIT_FILE = "fpga/firmware.hex",
  parameter int LED_W     = 4,
  parameter int CLK_HZ    = 100000000,
  parameter int BAUD      = 115200,
  parameter int TXF_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      imem_addr,
  output logic [31:0]      imem_rdata,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  input  logic             dmem_we,
  output logic [31:0]      dmem_rdata,
  input  logic             trap,
  output logic [LED_W-1:0] leds,
  output logic             uart_tx
);

  localparam int AW  = $clog2(MEM_WORDS);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(TXF_DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(TXF_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [31:0]      mem [0:MEM_WORDS-1];
  logic [LED_W-1:0] led_reg;
  logic [7:0]       fifo [0:TXF_DEPTH-1];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             ovf;
  logic [1:0]       state;
  logic [CW-1:0]    baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [31:0]      timer_val;

  wire [AW-1:0] dmem_word = dmem_addr[AW+1:2];
  wire [AW-1:0] imem_word = imem_addr[AW+1:2];
  wire [1:0]    io_sel    = dmem_addr[3:2];
  wire          is_ram    = (dmem_addr[31:28] == 4'h0);
  wire          is_io     = (dmem_addr[31:28] == 4'h1);
  wire          wr_led    = dmem_we && is_io && (io_sel == 2'd0);
  wire          wr_txd    = dmem_we && is_io && (io_sel == 2'd1);
  wire          wr_stat   = dmem_we && is_io && (io_sel == 2'd2);

  wire full  = (count == CNT_FULL);
  wire empty = (count == '0);
  wire busy  = (state != S_IDLE);
  wire push  = wr_txd && !full;
  wire pop   = (state == S_IDLE) && !empty;

  wire unused_bits = &{1'b0, imem_addr[31:AW+2], imem_addr[1:0], dmem_addr[27:AW+2], dmem_addr[1:0]};

  // RAM: asynchronous read on both ports, synchronous write from the data port
  always_ff @(posedge clk) begin
    if (dmem_we && is_ram) mem[dmem_word] <= dmem_wdata;
  end

  assign imem_rdata = mem[imem_word];

  // LED register and sticky overflow flag; a drop in the same cycle as a clear keeps ovf set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg <= '0;
      ovf     <= 1'b0;
    end else begin
      if (wr_led) led_reg <= dmem_wdata[LED_W-1:0];
      if (wr_stat && dmem_wdata[3]) ovf <= 1'b0;
      if (wr_txd && full) ovf <= 1'b1;
    end
  end

  assign leds = trap ? {LED_W{1'b1}} : led_reg;

  // TX FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= dmem_wdata[7:0];
  end

  // TX FIFO write pointer and occupancy; a pop never frees room for a push onto a full FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // UART framing FSM: the byte is latched at pop so its FIFO slot frees immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rd_ptr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (!empty) begin
            shreg  <= fifo[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
            state  <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Serial line decoded from FSM state so reset forces idle-high without waiting for a clock
  always_comb begin
    uart_tx = 1'b1;
    case (state)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shreg[bit_idx];
      default: uart_tx = 1'b1;
    endcase
  end

`ifdef HANSEN_MMIO_TIMER_EN
  logic [31:0] timer;

  // Free-running cycle counter; reads return the pre-increment value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer <= '0;
    else       timer <= timer + 32'd1;
  end

  assign timer_val = timer;
`else
  assign timer_val = '0;
`endif

  // Data-port read mux: RAM, IO page, or zero for unmapped regions
  always_comb begin
    dmem_rdata = '0;
    if (is_ram) begin
      dmem_rdata = mem[dmem_word];
    end else if (is_io) begin
      case (io_sel)
        2'd0:    dmem_rdata = 32'(led_reg);
        2'd2:    dmem_rdata = {28'b0, ovf, busy, empty, full};
        2'd3:    dmem_rdata = timer_val;
        default: dmem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hansen_soc_mem_io.sv
// tb/tb_hansen_soc_mem_io.sv - randomized self-checking bench for hansen_soc_mem_io
module tb_hansen_soc_mem_io;

  localparam int MEM_WORDS = 64;
  localparam int LED_W     = 4;
  localparam int CLK_HZ    = 1000;
  localparam int BAUD      = 100;
  localparam int TXF_DEPTH = 4;
  localparam int DIV       = CLK_HZ / BAUD;
  localparam int FRAME     = 10 * DIV + 1;

  localparam logic [31:0] A_LED  = 32'h1000_0000;
  localparam logic [31:0] A_TXD  = 32'h1000_0004;
  localparam logic [31:0] A_STAT = 32'h1000_0008;
  localparam logic [31:0] A_TMR  = 32'h1000_000C;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      imem_addr, imem_rdata;
  logic [31:0]      dmem_addr, dmem_wdata, dmem_rdata;
  logic             dmem_we;
  logic             trap;
  logic [LED_W-1:0] leds;
  logic             uart_tx;

  hansen_soc_mem_io #(
    .MEM_WORDS(MEM_WORDS), .INIT_FILE(""), .LED_W(LED_W),
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .TXF_DEPTH(TXF_DEPTH)
  ) dut (
    .clk(clk), .reset(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata), .trap(trap), .leds(leds), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0]      ram_m [MEM_WORDS];
  bit               ram_v [MEM_WORDS];
  logic [LED_W-1:0] led_m;
  logic [31:0]      written [$];

  logic [7:0] rx_q [$];
  int         rx_t [$];
  logic       rx_stop [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dmem_addr = a; dmem_wdata = d; dmem_we = 1'b1;
    #1;
    if (a[31:28] == 4'h0 && ram_v[word_of(a)])
      check("ram_old_data_on_write", dmem_rdata, ram_m[word_of(a)]);
    @(posedge clk);
    #1 dmem_we = 1'b0;
    if (a[31:28] == 4'h0) begin
      ram_m[word_of(a)] = d;
      ram_v[word_of(a)] = 1'b1;
    end else if (a[31:28] == 4'h1 && a[3:2] == 2'd0) begin
      led_m = d[LED_W-1:0];
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    dmem_addr = a; dmem_we = 1'b0;
    #1 d = dmem_rdata;
  endtask

  // Serial receiver: finds a start bit, samples each bit mid-period
  initial begin : rx_monitor
    int st;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        st = cyc;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        rx_q.push_back(b);
        rx_t.push_back(st);
        rx_stop.push_back(uart_tx);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd, t1, t2, a, d;
    logic [7:0]  bytes [6];
    logic [9:0]  frame_bits;
    int          n, zeros, waited;

    rst = 1'b1; imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; dmem_we = 1'b0; trap = 1'b0;
    led_m = '0;
    foreach (ram_v[i]) ram_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state
    #1;
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_uart_tx", 32'(uart_tx), 32'h1);
    bus_read(A_STAT, rd); check("rst_stat", rd, 32'h2);
    bus_read(A_LED, rd);  check("rst_led_reg", rd, 32'h0);
    bus_read(A_TXD, rd);  check("rst_txd_read", rd, 32'h0);

    // RAM wrap
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    bus_read(32'h0000_0010, rd); check("ram_deadbeef", rd, 32'hDEAD_BEEF);
    bus_read(32'h0000_0010 + MEM_WORDS * 4, rd); check("ram_wrap", rd, 32'hDEAD_BEEF);
    imem_addr = 32'h0000_0010 + MEM_WORDS * 12; #1;
    check("imem_wrap", imem_rdata, 32'hDEAD_BEEF);

    // Random RAM traffic, readback through aliases on both ports
    for (int i = 0; i < 40; i++) begin
      a = $urandom() & 32'h0FFF_FFFC;
      bus_write(a, $urandom());
      written.push_back(a);
    end
    for (int i = 0; i < 30; i++) begin
      a = written[$urandom_range(0, written.size() - 1)];
      a = (a % (MEM_WORDS * 4)) + MEM_WORDS * 4 * $urandom_range(0, 1000);
      bus_read(a, rd); check("ram_rand_dmem", rd, ram_m[word_of(a)]);
      imem_addr = a + MEM_WORDS * 4; #1;
      check("ram_rand_imem", imem_rdata, ram_m[word_of(a)]);
    end

    // Unmapped regions read 0 and do not disturb RAM
    for (int i = 0; i < 6; i++) begin
      a = written[$urandom_range(0, written.size() - 1)];
      a = {4'($urandom_range(2, 15)), a[27:0]};
      bus_write(a, $urandom());
      bus_read(a, rd); check("unmapped_read", rd, 32'h0);
      bus_read({4'h0, a[27:0]}, rd); check("unmapped_no_ram_write", rd, ram_m[word_of(a)]);
    end

    // LED register and trap override
    bus_write(A_LED, 32'h5);
    #1 check("led_5", 32'(leds), 32'h5);
    trap = 1'b1; #1 check("led_trap", 32'(leds), 32'hF);
    trap = 1'b0; #1 check("led_untrap", 32'(leds), 32'h5);
    for (int i = 0; i < 8; i++) begin
      bus_write(A_LED, $urandom());
      bus_read(A_LED, rd); check("led_readback", rd, 32'(led_m));
      trap = 1'($urandom_range(0, 1)); #1;
      check("led_pins", 32'(leds), trap ? 32'hF : 32'(led_m));
    end
    trap = 1'b0;

    // Single-byte waveforms: 0xA5 then random bytes
    for (int k = 0; k < 3; k++) begin
      bytes[0] = (k == 0) ? 8'hA5 : 8'($urandom());
      frame_bits = {1'b1, bytes[0], 1'b0};
      rx_q.delete(); rx_t.delete(); rx_stop.delete();
      bus_write(A_TXD, 32'(bytes[0]));
      dmem_addr = A_STAT; #1;
      check("tx_queued_stat", dmem_rdata, 32'h0);
      check("tx_queued_idle", 32'(uart_tx), 32'h1);
      @(posedge clk);
      for (int s = 0; s < 10 * DIV; s++) begin
        @(negedge clk); #1;
        check("tx_wave", 32'(uart_tx), 32'(frame_bits[s / DIV]));
        if (s == 5 * DIV) check("tx_busy_stat", dmem_rdata, 32'h6);
      end
      @(negedge clk); #1;
      check("tx_after_idle", 32'(uart_tx), 32'h1);
      check("tx_after_stat", dmem_rdata, 32'h2);
      check("tx_rx_count", 32'(rx_q.size()), 32'h1);
      if (rx_q.size() > 0) check("tx_rx_byte", 32'(rx_q[0]), 32'(bytes[0]));
    end

    // Overflow: six back-to-back pushes while idle
    rx_q.delete(); rx_t.delete(); rx_stop.delete();
    foreach (bytes[i]) bytes[i] = 8'($urandom());
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dmem_addr = A_TXD; dmem_wdata = 32'(bytes[i]); dmem_we = 1'b1;
    end
    @(negedge clk); dmem_we = 1'b0; dmem_addr = A_STAT; #1;
    check("ovf_stat", dmem_rdata, 32'hD);
    bus_write(A_STAT, 32'h8);
    bus_read(A_STAT, rd); check("ovf_cleared", rd, 32'h5);
    waited = 0;
    while (rx_q.size() < 5 && waited < 6 * FRAME) begin
      @(negedge clk); waited++;
    end
    check("ovf_rx_count", 32'(rx_q.size()), 32'h5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      check("ovf_rx_byte", 32'(rx_q[i]), 32'(bytes[i]));
      check("ovf_rx_stop", 32'(rx_stop[i]), 32'h1);
      if (i > 0) check("ovf_frame_spacing", 32'(rx_t[i] - rx_t[i-1]), 32'(FRAME));
    end
    repeat (2 * FRAME) @(negedge clk);
    check("ovf_no_sixth", 32'(rx_q.size()), 32'h5);
    bus_read(A_STAT, rd); check("ovf_final_stat", rd, 32'h2);

    // Reset in the middle of data bit 3, with a second byte still queued
    bus_write(A_LED, 32'h9);
    bus_write(A_TXD, 32'h37);
    bus_write(A_TXD, 32'($urandom()));
    repeat (45) @(negedge clk);
    #1 check("mid_bit3_low", 32'(uart_tx), 32'h0);
    dmem_addr = A_STAT;
    rst = 1'b1; led_m = '0;
    #1;
    check("rst_async_tx", 32'(uart_tx), 32'h1);
    check("rst_async_stat", dmem_rdata, 32'h2);
    check("rst_async_leds", 32'(leds), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    rx_q.delete(); rx_t.delete(); rx_stop.delete();
    zeros = 0;
    for (int s = 0; s < 2 * FRAME; s++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) zeros++;
    end
    check("post_rst_quiet", 32'(zeros), 32'h0);
    check("post_rst_no_rx", 32'(rx_q.size()), 32'h0);

    // Timer read twice N cycles apart
    n = $urandom_range(3, 60);
    bus_read(A_TMR, t1);
    repeat (n) @(negedge clk);
    #1 t2 = dmem_rdata;
`ifdef HANSEN_MMIO_TIMER_EN
    check("timer_delta", t2 - t1, 32'(n));
`else
    check("timer_absent_1", t1, 32'h0);
    check("timer_absent_2", t2, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
